// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory request/response
// channel and the decoder-facing valid/ready instruction channel.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  // Fetch unit side.
  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data,
           instr_ready,
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc
  );

  // Environment side (memory, decoder, branch resolution).
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data,
           instr_ready,
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word requests, buffers
// returned words with their addresses and hands {instr, pc} to the decoder.
// A redirect flushes the buffer and discards every response still in flight.
// Optional: define FETCH_PERF_CNT_EN to add fetch/stall/flush event counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_stall_cnt,
  output logic [31:0]  perf_flush_cnt
`endif
);

  localparam int unsigned     AW      = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W:0]  DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic             active_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [31:0] data_mem_q [FIFO_DEPTH];
  logic [31:0] pc_mem_q   [FIFO_DEPTH];
  logic [31:0] tag_mem_q  [FIFO_DEPTH];

  logic           head_valid, pop, accept, resp_keep, push;
  logic [CNT_W:0] occupancy;

  assign head_valid = (cnt_q != '0);
  assign pop        = head_valid && bus.instr_ready;

  // Credit: buffered + in-flight words (after this cycle's pop) must leave room,
  // so every response is guaranteed a slot.
  assign occupancy  = {1'b0, cnt_q} + {1'b0, out_q} - {{CNT_W{1'b0}}, pop};

  // active_q holds requests off for the first cycle after reset.
  assign bus.imem_req_valid = !reset && active_q && !bus.redirect_valid &&
                              (occupancy < DEPTH_W);
  assign bus.imem_req_addr  = pc_q;
  assign accept             = bus.imem_req_valid && bus.imem_req_ready;

  // A response is kept only when no pre-redirect words remain to be discarded.
  assign resp_keep = bus.imem_resp_valid && (drop_q == '0);
  assign push      = resp_keep && !bus.redirect_valid;

  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_valid ? data_mem_q[rd_ptr_q] : '0;
  assign bus.instr_pc    = head_valid ? pc_mem_q[rd_ptr_q]   : '0;

  // Next-state for PC, counters and queue pointers; redirect overrides all.
  always_comb begin
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    out_d    = out_q + CNT_W'(accept) - CNT_W'(bus.imem_resp_valid);
    drop_d   = drop_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    tag_rd_d = tag_rd_q;
    tag_wr_d = tag_wr_q;
    if (bus.redirect_valid) begin
      pc_d     = {bus.redirect_pc[31:2], 2'b00};
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      tag_rd_d = '0;
      tag_wr_d = '0;
      // No request is accepted this cycle, so everything still outstanding
      // after this cycle's response belongs to the old path.
      drop_d   = out_d;
    end else begin
      if (accept) begin
        pc_d     = pc_q + 32'd4;
        tag_wr_d = tag_wr_q + AW'(1);
      end
      if (bus.imem_resp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CNT_W'(1);
      end
      if (resp_keep) begin
        tag_rd_d = tag_rd_q + AW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      active_q <= 1'b0;
      cnt_q    <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      active_q <= 1'b1;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
    end
  end

  // Storage: request address queue and instruction buffer (no reset needed).
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem_q[tag_wr_q] <= pc_q;
    end
    if (push) begin
      data_mem_q[wr_ptr_q] <= bus.imem_resp_data;
      pc_mem_q[wr_ptr_q]   <= tag_mem_q[tag_rd_q];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

  // Free-running wrapping event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (accept) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (bus.instr_ready && !head_valid) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (bus.redirect_valid) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

`ifndef SYNTHESIS
  // The credit check makes both of these unreachable.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    push |-> (cnt_q != DEPTH_C));
  a_no_spurious_resp : assert property (@(posedge clk) disable iff (reset)
    bus.imem_resp_valid |-> (out_q != '0));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-exact vector table for ramp-up/backpressure,
// then directed redirect/reset sequences and a randomized run, all checked by
// an address scoreboard against a memory model.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int          DEPTH    = 4;

  typedef struct {
    logic        req_ready;
    logic        instr_ready;
    logic        exp_req_valid;
    logic [31:0] exp_addr;
    logic        exp_instr_valid;
    logic [31:0] exp_instr_pc;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q [$];
  pend_t       pend_q [$];
  int          cyc      = 0;
  int          last_due = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  int          n_acc    = 0;
  logic [31:0] model_pc = RESET_PC;
  logic        s_req_valid, s_instr_valid;
  logic [31:0] s_addr, s_instr, s_instr_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h0F0F};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample at negedge, update models/scoreboard, then drive the
  // memory response for the next cycle just after the posedge.
  task automatic step();
    logic        acc, pop;
    int          due;
    logic [31:0] e;
    @(negedge clk);
    s_req_valid   = bus.imem_req_valid;
    s_addr        = bus.imem_req_addr;
    s_instr_valid = bus.instr_valid;
    s_instr       = bus.instr;
    s_instr_pc    = bus.instr_pc;
    acc = s_req_valid && bus.imem_req_ready;
    pop = s_instr_valid && bus.instr_ready;
    if (reset) begin
      exp_q.delete();
      pend_q.delete();
      last_due = 0;
      model_pc = RESET_PC;
      n_acc    = 0;
    end else begin
      if (acc) begin
        check("req_addr", s_addr, model_pc);
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_q.push_back('{due: due, addr: s_addr});
        exp_q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
        n_acc++;
      end
      if (bus.redirect_valid) begin
        exp_q.delete();
        model_pc = bus.redirect_pc & 32'hFFFF_FFFC;
      end else if (pop) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got pc %08h, expected no word (cycle %0d)",
                   s_instr_pc, cyc);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", s_instr_pc, e);
          check("instr", s_instr, mem_word(e));
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!reset && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    step();
    step();
    check("rst_req_valid", 32'(s_req_valid), 32'd0);
    check("rst_instr_valid", 32'(s_instr_valid), 32'd0);
    reset = 1'b0;
  endtask

  task automatic redir(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    bus.imem_req_ready = 1'b0;
    bus.instr_ready    = 1'b1;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 50) begin
      step();
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_head(input string name);
    int n;
    n = 0;
    step();
    while (!s_instr_valid && n < 20) begin
      step();
      n++;
    end
    check({name, "_head_valid"}, 32'(s_instr_valid), 32'd1);
  endtask

  initial begin
    vec_t vecs [12];
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,             1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, RESET_PC,          1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, RESET_PC + 32'h04, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, RESET_PC + 32'h08, 1'b1, RESET_PC};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, RESET_PC + 32'h0C, 1'b1, RESET_PC + 32'h04};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, RESET_PC + 32'h10, 1'b1, RESET_PC + 32'h08};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, RESET_PC + 32'h14, 1'b1, RESET_PC + 32'h0C};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, RESET_PC + 32'h18, 1'b1, RESET_PC + 32'h0C};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,             1'b1, RESET_PC + 32'h0C};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,             1'b1, RESET_PC + 32'h0C};
    vecs[10] = '{1'b1, 1'b1, 1'b1, RESET_PC + 32'h1C, 1'b1, RESET_PC + 32'h0C};
    vecs[11] = '{1'b1, 1'b1, 1'b1, RESET_PC + 32'h20, 1'b1, RESET_PC + 32'h10};

    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.instr_ready     = 1'b0;

    // Ramp-up, latency, throughput and full-buffer credit, cycle by cycle.
    lat_min = 1;
    lat_max = 1;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      bus.imem_req_ready = vecs[i].req_ready;
      bus.instr_ready    = vecs[i].instr_ready;
      step();
      check($sformatf("vec%0d_req_valid", i), 32'(s_req_valid), 32'(vecs[i].exp_req_valid));
      if (vecs[i].exp_req_valid) begin
        check($sformatf("vec%0d_req_addr", i), s_addr, vecs[i].exp_addr);
      end
      check($sformatf("vec%0d_instr_valid", i), 32'(s_instr_valid),
            32'(vecs[i].exp_instr_valid));
      check($sformatf("vec%0d_instr_pc", i), s_instr_pc, vecs[i].exp_instr_pc);
    end

    // Decoder stalled for 10 cycles: buffer fills to exactly DEPTH, then drains in order.
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("bp_req_valid", 32'(s_req_valid), 32'd0);
    check("bp_buffered", 32'(exp_q.size()), 32'(DEPTH));
    check("bp_in_flight", 32'(pend_q.size()), 32'd0);
    drain("bp");

    // Redirect with two requests in flight: both responses are discarded.
    lat_min = 3;
    lat_max = 3;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b0;
    step();
    step();
    check("redir_in_flight", 32'(pend_q.size()), 32'd2);
    redir(32'h0000_1002);
    wait_head("redir");
    check("redir_first_pc", s_instr_pc, 32'h0000_1000);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    step();
    check("redir_second_pc", s_instr_pc, 32'h0000_1004);
    drain("redir");

    // Redirect in the same cycle as a response and a pop.
    lat_min = 1;
    lat_max = 1;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    for (int i = 0; i < 6; i++) step();
    redir(32'h0000_2000);
    check("coinc_pre_valid", 32'(s_instr_valid), 32'd1);
    step();
    check("coinc_empty", 32'(s_instr_valid), 32'd0);
    check("coinc_req_valid", 32'(s_req_valid), 32'd1);
    check("coinc_req_addr", s_addr, 32'h0000_2000);
    drain("coinc");

    // Back-to-back redirects: the last target wins.
    lat_min = 2;
    lat_max = 2;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b0;
    step();
    step();
    redir(32'h0000_3000);
    redir(32'h0000_4006);
    wait_head("b2b");
    check("b2b_first_pc", s_instr_pc, 32'h0000_4004);
    drain("b2b");

    // Reset in mid-operation.
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    for (int i = 0; i < 5; i++) step();
    apply_reset();
    step();
    check("rst2_first_req_valid", 32'(s_req_valid), 32'd0);
    check("rst2_first_instr_valid", 32'(s_instr_valid), 32'd0);
    check("rst2_first_instr_pc", s_instr_pc, 32'd0);
    step();
    check("rst2_req_valid", 32'(s_req_valid), 32'd1);
    check("rst2_req_addr", s_addr, RESET_PC);
    drain("rst2");

    // Random ready/latency with random redirects.
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      bus.imem_req_ready = ($urandom_range(9, 0) < 7);
      bus.instr_ready    = ($urandom_range(9, 0) < 7);
      if ($urandom_range(19, 0) == 0) begin
        redir($urandom());
      end else begin
        step();
      end
    end
    drain("rand");

`ifdef FETCH_PERF_CNT_EN
    // 3 redirects and 5 starved decoder cycles with no fetching.
    bus.imem_req_ready = 1'b0;
    bus.instr_ready    = 1'b0;
    apply_reset();
    redir(32'h0000_0100);
    redir(32'h0000_0200);
    redir(32'h0000_0300);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus.instr_ready = 1'b0;
    step();
    check("perf_flush", perf_flush_cnt, 32'd3);
    check("perf_stall", perf_stall_cnt, 32'd5);
    check("perf_fetch_idle", perf_fetch_cnt, 32'd0);
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.imem_req_ready = 1'b0;
    step();
    check("perf_fetch", perf_fetch_cnt, 32'(n_acc));
    drain("perf");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
